// File: rtl/control_unit.sv
// control_unit
//   Sequencer for the datapath register command buses. Accepts one
//   instruction at a time through start/busy/done. It expands the instruction
//   into one or more EXEC cycles of X/Y/Z register commands and ULA selects.
//   All buses return to HOLD outside EXEC.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    instruction request, sampled only in IDLE
//   opcode   instruction, latched with start
//   arg      shift count for SHRY/SHLY, latched with start
//   tx/ty/tz X/Y/Z register commands (HOLD/LOAD/SHIFTR/SHIFTL/RESET)
//   tula     ULA operation select (PASS/ADD/SUB/PASSY)
//   busy     high in EXEC and DONE
//   done     one-cycle completion pulse
//   illegal  pulses with done when the latched opcode was unassigned
module control_unit #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [CNT_W-1:0] arg,
    output logic [2:0]       tx,
    output logic [2:0]       ty,
    output logic [2:0]       tz,
    output logic [1:0]       tula,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        CMD_HOLD   = 3'b000,
        CMD_LOAD   = 3'b001,
        CMD_SHIFTR = 3'b010,
        CMD_SHIFTL = 3'b011,
        CMD_RESET  = 3'b100
    } cmd_t;

    typedef enum logic [1:0] {
        ULA_PASS  = 2'b00,
        ULA_ADD   = 2'b01,
        ULA_SUB   = 2'b10,
        ULA_PASSY = 2'b11
    } ula_t;

    typedef enum logic [3:0] {
        OP_NOP    = 4'b0000,
        OP_CLR    = 4'b0001,
        OP_LDX    = 4'b0010,
        OP_ADDY   = 4'b0011,
        OP_SUBY   = 4'b0100,
        OP_SHRY   = 4'b0101,
        OP_SHLY   = 4'b0110,
        OP_MOVZ   = 4'b0111,
        OP_ADDMOV = 4'b1000
    } op_t;

    typedef struct packed {
        cmd_t cx;
        cmd_t cy;
        cmd_t cz;
        ula_t cu;
    } cmds_t;

    localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] CNT_TWO = (CNT_W+1)'(2);

    // Number of EXEC steps an instruction occupies.
    function automatic logic [CNT_W:0] step_count(input logic [3:0] op,
                                                  input logic [CNT_W-1:0] a);
        logic [CNT_W:0] n;
        n = CNT_ONE;
        case (op)
            OP_SHRY, OP_SHLY: n = {1'b0, a};
            OP_ADDMOV:        n = CNT_TWO;
            default:          n = CNT_ONE;
        endcase
        return n;
    endfunction

    // Commands for the EXEC cycle in which the step counter holds step_cnt.
    // The counter runs down, so ADDMOV's first step is step_cnt==2.
    function automatic cmds_t decode(input logic [3:0] op,
                                     input logic [CNT_W:0] step_cnt);
        cmds_t c;
        c = '{cx: CMD_HOLD, cy: CMD_HOLD, cz: CMD_HOLD, cu: ULA_PASS};
        case (op)
            OP_CLR: begin
                c.cx = CMD_RESET;
                c.cy = CMD_RESET;
                c.cz = CMD_RESET;
            end
            OP_LDX:  c.cx = CMD_LOAD;
            OP_ADDY: begin
                c.cy = CMD_LOAD;
                c.cu = ULA_ADD;
            end
            OP_SUBY: begin
                c.cy = CMD_LOAD;
                c.cu = ULA_SUB;
            end
            OP_SHRY: c.cy = CMD_SHIFTR;
            OP_SHLY: c.cy = CMD_SHIFTL;
            OP_MOVZ: begin
                c.cz = CMD_LOAD;
                c.cu = ULA_PASSY;
            end
            OP_ADDMOV: begin
                if (step_cnt == CNT_TWO) begin
                    c.cy = CMD_LOAD;
                    c.cu = ULA_ADD;
                end else begin
                    c.cz = CMD_LOAD;
                    c.cu = ULA_PASSY;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t         state;
    logic [3:0]     op_q;
    logic [CNT_W:0] cnt;

    logic [CNT_W:0] start_steps;
    cmds_t          start_cmds;
    cmds_t          next_cmds;

    // Outputs are registered, so the commands for the upcoming EXEC cycle
    // are decoded one cycle ahead from the incoming or latched opcode.
    always_comb begin
        start_steps = step_count(opcode, arg);
        start_cmds  = decode(opcode, start_steps);
        next_cmds   = decode(op_q, cnt - CNT_ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            cnt     <= '0;
            tx      <= CMD_HOLD;
            ty      <= CMD_HOLD;
            tz      <= CMD_HOLD;
            tula    <= ULA_PASS;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    if (start) begin
                        op_q <= opcode;
                        cnt  <= start_steps;
                        busy <= 1'b1;
                        if (start_steps == '0) begin
                            // Zero-count shift: nothing to issue, finish now.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                            tx    <= start_cmds.cx;
                            ty    <= start_cmds.cy;
                            tz    <= start_cmds.cz;
                            tula  <= start_cmds.cu;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_ONE) begin
                        state   <= S_DONE;
                        tx      <= CMD_HOLD;
                        ty      <= CMD_HOLD;
                        tz      <= CMD_HOLD;
                        tula    <= ULA_PASS;
                        done    <= 1'b1;
                        illegal <= (op_q > OP_ADDMOV);
                    end else begin
                        cnt  <= cnt - CNT_ONE;
                        tx   <= next_cmds.cx;
                        ty   <= next_cmds.cy;
                        tz   <= next_cmds.cz;
                        tula <= next_cmds.cu;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    illegal <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Scoreboard bench for control_unit. The driver issues instructions and
//   pushes the expected per-cycle observations into a queue. A monitor
//   samples every falling edge and pops one entry per cycle. When the queue
//   is empty, it expects the idle (all-zero) outputs.
module tb_control_unit;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       opcode = '0;
    logic [CNT_W-1:0] arg = '0;
    logic [2:0]       tx, ty, tz;
    logic [1:0]       tula;
    logic             busy, done, illegal;

    control_unit #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opcode  (opcode),
        .arg     (arg),
        .tx      (tx),
        .ty      (ty),
        .tz      (tz),
        .tula    (tula),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] z;
        logic [1:0] u;
        logic       b;
        logic       d;
        logic       il;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.x = tx; o.y = ty; o.z = tz; o.u = tula;
        o.b = busy; o.d = done; o.il = illegal;
        return o;
    endfunction

    function automatic obs_t mk(input logic [2:0] x, input logic [2:0] y,
                                input logic [2:0] z, input logic [1:0] u);
        obs_t o;
        o.x = x; o.y = y; o.z = z; o.u = u;
        o.b = 1'b1; o.d = 1'b0; o.il = 1'b0;
        return o;
    endfunction

    // Monitor: one comparison per cycle.
    always @(negedge clk) begin
        obs_t a, e;
        if (mon_en) begin
            a = sample();
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle t=%0t actual tx=%b ty=%b tz=%b tula=%b busy=%b done=%b illegal=%b required tx=%b ty=%b tz=%b tula=%b busy=%b done=%b illegal=%b",
                         $time, a.x, a.y, a.z, a.u, a.b, a.d, a.il,
                         e.x, e.y, e.z, e.u, e.b, e.d, e.il);
            end
        end
    end

    // Reference model: the cycle-by-cycle observations after an accepted
    // start, built from the opcode table. Returns the number of busy cycles.
    task automatic expect_instr(input logic [3:0] op, input logic [CNT_W-1:0] a,
                                output int nbusy);
        obs_t d;
        int   n0;
        n0 = exp_q.size();
        case (op)
            4'd0: exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00));
            4'd1: exp_q.push_back(mk(3'b100, 3'b100, 3'b100, 2'b00));
            4'd2: exp_q.push_back(mk(3'b001, 3'b000, 3'b000, 2'b00));
            4'd3: exp_q.push_back(mk(3'b000, 3'b001, 3'b000, 2'b01));
            4'd4: exp_q.push_back(mk(3'b000, 3'b001, 3'b000, 2'b10));
            4'd5: for (int i = 0; i < int'(a); i++)
                      exp_q.push_back(mk(3'b000, 3'b010, 3'b000, 2'b00));
            4'd6: for (int i = 0; i < int'(a); i++)
                      exp_q.push_back(mk(3'b000, 3'b011, 3'b000, 2'b00));
            4'd7: exp_q.push_back(mk(3'b000, 3'b000, 3'b001, 2'b11));
            4'd8: begin
                exp_q.push_back(mk(3'b000, 3'b001, 3'b000, 2'b01));
                exp_q.push_back(mk(3'b000, 3'b000, 3'b001, 2'b11));
            end
            default: exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00));
        endcase
        d = '0;
        d.b = 1'b1;
        d.d = 1'b1;
        d.il = (op > 4'd8);
        exp_q.push_back(d);
        nbusy = exp_q.size() - n0;
    endtask

    // Called at #1 after an edge with the DUT idle at the next edge.
    // With noise, start/opcode/arg are scrambled while busy (must be ignored).
    task automatic issue(input logic [3:0] op, input logic [CNT_W-1:0] a,
                         input bit noise);
        int nb;
        start = 1'b1;
        opcode = op;
        arg = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_instr(op, a, nb);
        for (int i = 0; i < nb; i++) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                opcode = 4'($urandom_range(0, 15));
                arg = CNT_W'($urandom);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int nb;
        obs_t a;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        idle_cycles(5);

        issue(4'b0001, 2'd0, 1'b0);   // CLR
        issue(4'b0110, 2'd3, 1'b0);   // SHLY 3
        idle_cycles(1);
        issue(4'b0101, 2'd0, 1'b0);   // SHRY 0
        issue(4'b1000, 2'd1, 1'b0);   // ADDMOV
        issue(4'b1010, 2'd2, 1'b1);   // illegal, with start pulsed while busy
        idle_cycles(2);

        // Reset in cycle k+2 of SHLY 3.
        start = 1'b1;
        opcode = 4'b0110;
        arg = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_instr(4'b0110, 2'd3, nb);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        a = sample();
        tests++;
        if (a !== obs_t'('0)) begin
            fails++;
            $display("FAIL async_reset actual=%b required=%b", a, obs_t'('0));
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(6);

        for (int t = 0; t < 200; t++) begin
            issue(4'($urandom_range(0, 15)), CNT_W'($urandom),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(3);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencer that drives the per-register command buses of the datapath: the 3-bit `tx`/`ty`/`tz` commands consumed by the X, Y and Z registers, and the 2-bit `tula` operation select for the ULA. It accepts one instruction at a time through a start/busy/done handshake. It expands each instruction into one or more cycles of register commands, and returns every command bus to HOLD when idle. It is the issuing end of the register command interface.

## Interface
- `CNT_W`, default 2: width of `arg` (shift count). Maximum shift count is 2^CNT_W - 1.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: instruction request. Sampled only in IDLE.
- `opcode` input 4: instruction, latched with `start`.
- `arg` input CNT_W: shift count for SHRY/SHLY, latched with `start`. Ignored for other opcodes.
- `tx` output 3: X register command.
- `ty` output 3: Y register command.
- `tz` output 3: Z register command.
- `tula` output 2: ULA operation select.
- `busy` output 1: instruction in progress. High in EXEC and DONE.
- `done` output 1: one-cycle completion pulse.
- `illegal` output 1: pulses with `done` when the latched opcode was unassigned.

## Operation
- Command encoding, fixed: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100. Codes 101–111 are never driven.
- ULA encoding, fixed: 00 PASS (data bus), 01 ADD (X+Y), 10 SUB (X−Y), 11 PASSY.
- States:
  - IDLE → EXEC on `start`. Latches `opcode` and `arg`, and loads the step counter.
  - EXEC → EXEC while steps remain.
  - EXEC → DONE after the last step.
  - DONE → IDLE unconditionally.
- Outputs are decoded from state, latched opcode and step count. `tx`/`ty`/`tz` are HOLD and `tula`=00 in every state other than EXEC.
- Opcodes, with the EXEC-cycle commands (unlisted buses are HOLD, unlisted `tula` is 00):
  - 0000 NOP: 1 step, all HOLD.
  - 0001 CLR: 1 step, tx=ty=tz=RESET.
  - 0010 LDX: 1 step, tx=LOAD, tula=00.
  - 0011 ADDY: 1 step, ty=LOAD, tula=01.
  - 0100 SUBY: 1 step, ty=LOAD, tula=10.
  - 0101 SHRY: `arg` steps, ty=SHIFTR each step.
  - 0110 SHLY: `arg` steps, ty=SHIFTL each step.
  - 0111 MOVZ: 1 step, tz=LOAD, tula=11.
  - 1000 ADDMOV: 2 steps.
    - Step 1: ty=LOAD, tula=01.
    - Step 2: tz=LOAD, tula=11.
  - 1001–1111: illegal. 1 step, all HOLD, `illegal`=1 during DONE.
- SHRY/SHLY with `arg`=0: IDLE → DONE directly. No EXEC cycle, no command issued.
- The step counter is CNT_W+1 bits wide. It decrements each EXEC cycle and leaves EXEC when it reaches 1.

## Timing
- Reset values: state IDLE; `tx`=`ty`=`tz`=000; `tula`=00; `busy`=`done`=`illegal`=0.
- Reset takes effect immediately, including mid-instruction.
  - Any EXEC step not yet clocked is abandoned.
  - No DONE pulse is generated for the abandoned instruction.
  - Downstream registers are not reset by this block.
- `start` is high at edge k in IDLE:
  - EXEC occupies cycles k+1 … k+n, where n is the number of steps.
  - Each step's command is applied by the register at the edge that ends that cycle.
  - DONE occurs in cycle k+n+1, with `done`=1 for exactly that cycle.
  - IDLE is reached at cycle k+n+2.
- Zero-step shift: DONE is in cycle k+1.
- Latency from `start` to `done` is n+1 cycles. The minimum issue interval is n+2 cycles.
- `start` while `busy`=1 is ignored and is not queued. `opcode`/`arg` changes after latching have no effect.
- `start` held high continuously: a new instruction is accepted on the first IDLE edge after DONE.
- `busy` is low only in IDLE. `busy` and `done` are never asserted in the same cycle as IDLE.

## Test plan
- Reset, then hold idle 5 cycles:
  - Required: tx=ty=tz=000, tula=00, busy=0, done=0 throughout.
- CLR, `start` at edge k:
  - Cycle k+1: tx=ty=tz=100, busy=1.
  - Cycle k+2: done=1, all buses 000.
  - Cycle k+3: busy=0.
- SHLY with arg=3:
  - Cycles k+1..k+3: ty=011.
  - Cycle k+4: done=1.
- SHRY with arg=0:
  - No cycle with ty≠000.
  - done=1 at cycle k+1.
- ADDMOV:
  - Cycle k+1: ty=001, tula=01.
  - Cycle k+2: tz=001, tula=11, ty=000.
  - Cycle k+3: done=1.
- Opcode 1010:
  - One EXEC cycle with all buses HOLD, then done=1 and illegal=1 together.
  - A second `start` pulsed during busy is ignored.
  - `rst` asserted in cycle k+2 of SHLY arg=3 forces all outputs to 0 before the next edge, and no done pulse follows.
